// File: rtl/dadda_arb_pkg.sv
// Shared parameters, state type and round-robin helper for the dadda_arbiter slice.
package dadda_arb_pkg;

  localparam int N_REQ  = 4;
  localparam int OP_W   = 8;
  localparam int PROD_W = 16;
  localparam int ID_W   = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    RESP = 2'd2
  } state_e;

  // First requester with valid set, searching upward from ptr and wrapping.
  // The index is ID_W wide, so ptr + offset wraps modulo N_REQ for free.
  function automatic logic [ID_W-1:0] rr_pick(input logic [N_REQ-1:0] valid,
                                               input logic [ID_W-1:0]  ptr);
    logic [ID_W-1:0] idx;
    logic [ID_W-1:0] pick;
    pick = ptr;
    // Walk from the farthest offset down so the nearest valid is the last write.
    for (int off = N_REQ - 1; off >= 0; off--) begin
      idx = ptr + ID_W'(off);
      if (valid[idx]) pick = idx;
    end
    return pick;
  endfunction

endpackage

// File: rtl/dadda_final.sv
// Combinational unsigned 8x8 multiplier shared by all requesters.
module dadda_final
  import dadda_arb_pkg::*;
(
  input  logic [OP_W-1:0]   a,
  input  logic [OP_W-1:0]   b,
  output logic [PROD_W-1:0] prod
);

  // Sum the shifted partial-product rows; the full 16-bit width keeps 255*255 exact.
  always_comb begin
    // NOTE: every variable written in always_comb gets a value before any branch,
    // otherwise a path that skips the write infers a latch.
    prod = '0;
    for (int i = 0; i < OP_W; i++) begin
      if (b[i]) prod = prod + (PROD_W'(a) << i);
    end
  end

endmodule

// File: rtl/dadda_arbiter.sv
// Round-robin arbiter sharing one dadda_final multiplier among N_REQ requesters.
// Optional macro DADDA_ARB_PIPE_EN adds a product register and the CALC state
// (accept -> CALC -> RESP); without it accept goes straight to RESP.
module dadda_arbiter
  import dadda_arb_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [N_REQ*OP_W-1:0]   req_a,
  input  logic [N_REQ*OP_W-1:0]   req_b,
  output logic [N_REQ-1:0]        req_ready,
  output logic                    rsp_valid,
  output logic [ID_W-1:0]         rsp_id,
  output logic [PROD_W-1:0]       rsp_prod,
  input  logic                    rsp_ready,
  output logic                    busy
);

`ifdef DADDA_ARB_PIPE_EN
  localparam state_e ACCEPT_STATE = CALC;
`else
  localparam state_e ACCEPT_STATE = RESP;
`endif

  state_e            state_q,  state_d;
  logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [OP_W-1:0]   op_a_q,   op_a_d;
  logic [OP_W-1:0]   op_b_q,   op_b_d;
  logic [ID_W-1:0]   op_id_q,  op_id_d;
  logic [PROD_W-1:0] mult_out;
  logic [ID_W-1:0]   grant_idx;
  logic              retire;
  logic              accept;
`ifdef DADDA_ARB_PIPE_EN
  logic [PROD_W-1:0] prod_q,   prod_d;
`endif

  // The multiplier only ever sees the registered operands.
  dadda_final u_mult (
    .a    (op_a_q),
    .b    (op_b_q),
    .prod (mult_out)
  );

  // Grant selection, handshake decode and next-state/next-register values.
  always_comb begin
    grant_idx = rr_pick(req_valid, rr_ptr_q);
    retire    = (state_q == RESP) && rsp_ready;
    // Reset wins over any handshake, so no grant is offered while rst is high.
    accept    = !rst && (|req_valid) && ((state_q == IDLE) || retire);
    req_ready = '0;
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    op_a_d    = op_a_q;
    op_b_d    = op_b_q;
    op_id_d   = op_id_q;
    if (accept) begin
      req_ready[grant_idx] = 1'b1;
      op_a_d   = req_a[int'(grant_idx)*OP_W +: OP_W];
      op_b_d   = req_b[int'(grant_idx)*OP_W +: OP_W];
      op_id_d  = grant_idx;
      rr_ptr_d = grant_idx + ID_W'(1);
    end
    case (state_q)
      IDLE:    if (accept) state_d = ACCEPT_STATE;
      CALC:    state_d = RESP;
      RESP:    if (retire) state_d = accept ? ACCEPT_STATE : IDLE;
      default: state_d = IDLE;
    endcase
  end

`ifdef DADDA_ARB_PIPE_EN
  // Capture the product during CALC; it is held for the whole RESP phase.
  always_comb begin
    prod_d = prod_q;
    if (state_q == CALC) prod_d = mult_out;
  end
`endif

  // State, pointer and operand registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the operand registers are reset as well so rsp_id/rsp_prod read
      // zero after reset instead of stale data from a discarded operation.
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      op_a_q   <= '0;
      op_b_q   <= '0;
      op_id_q  <= '0;
`ifdef DADDA_ARB_PIPE_EN
      prod_q   <= '0;
`endif
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      op_a_q   <= op_a_d;
      op_b_q   <= op_b_d;
      op_id_q  <= op_id_d;
`ifdef DADDA_ARB_PIPE_EN
      prod_q   <= prod_d;
`endif
    end
  end

  assign rsp_valid = (state_q == RESP);
  assign rsp_id    = op_id_q;
  assign busy      = (state_q != IDLE);
`ifdef DADDA_ARB_PIPE_EN
  assign rsp_prod  = prod_q;
`else
  assign rsp_prod  = mult_out;
`endif

endmodule

// File: tb/tb_dadda_arbiter.sv
// Self-checking bench for dadda_arbiter: directed scenarios plus a randomized
// regression, all checked against a transaction-level reference model.
module tb_dadda_arbiter;

`ifdef DADDA_ARB_PIPE_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 0;
`endif

  typedef struct {
    int id;
    int prod;
  } rsp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  req_valid = '0;
  logic [31:0] req_a = '0;
  logic [31:0] req_b = '0;
  logic [3:0]  req_ready;
  logic        rsp_valid;
  logic [1:0]  rsp_id;
  logic [15:0] rsp_prod;
  logic        rsp_ready = 1'b0;
  logic        busy;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: one outstanding job, visible once its latency counts out.
  bit m_occ = 0;
  int m_lat = 0;
  int m_id  = 0;
  int m_prod = 0;
  int m_ptr = 0;
  int acc_cnt [4];
  int ret_cnt [4];
  int disc_cnt[4];
  int dut_ret [4];

  rsp_t rsp_log[$];
  int   grant_log[$];
  int   last_grant;

  dadda_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_id    (rsp_id),
    .rsp_prod  (rsp_prod),
    .rsp_ready (rsp_ready),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // One clock: compare outputs to the model at negedge, advance the model at posedge.
  task automatic cycle();
    int         exp_g;
    bit         vis;
    bit         allowed;
    bit         acc;
    bit         ret;
    logic [3:0] exp_ready;
    rsp_t       r;
    @(negedge clk);
    vis     = m_occ && (m_lat == 0);
    allowed = !rst && (!m_occ || (vis && rsp_ready));
    exp_g   = -1;
    for (int k = 0; k < 4; k++) begin
      int j;
      j = (m_ptr + k) % 4;
      if (exp_g < 0 && req_valid[j]) exp_g = j;
    end
    exp_ready = '0;
    if (allowed && exp_g >= 0) exp_ready[exp_g] = 1'b1;
    n_tests++;
    if (req_ready !== exp_ready) begin
      n_fail++;
      $display("FAIL model_req_ready: got %b expected %b at %0t", req_ready, exp_ready, $time);
    end
    n_tests++;
    if (rsp_valid !== vis) begin
      n_fail++;
      $display("FAIL model_rsp_valid: got %b expected %b at %0t", rsp_valid, vis, $time);
    end
    n_tests++;
    if (busy !== m_occ) begin
      n_fail++;
      $display("FAIL model_busy: got %b expected %b at %0t", busy, m_occ, $time);
    end
    if (vis) begin
      n_tests++;
      if (rsp_id !== 2'(m_id) || rsp_prod !== 16'(m_prod)) begin
        n_fail++;
        $display("FAIL model_rsp_data: got id=%0d prod=%0d expected id=%0d prod=%0d at %0t",
                 rsp_id, rsp_prod, m_id, m_prod, $time);
      end
    end
    acc = allowed && (exp_g >= 0);
    ret = vis && rsp_ready && !rst;
    last_grant = -1;
    if (!rst && rsp_valid === 1'b1 && rsp_ready) begin
      r.id = int'(rsp_id);
      r.prod = int'(rsp_prod);
      rsp_log.push_back(r);
      dut_ret[rsp_id]++;
    end
    for (int i = 0; i < 4; i++) begin
      if (!rst && req_valid[i] && req_ready[i] === 1'b1) begin
        grant_log.push_back(i);
        last_grant = i;
      end
    end
    @(posedge clk);
    if (rst) begin
      if (m_occ) disc_cnt[m_id]++;
      m_occ = 0;
      m_lat = 0;
      m_ptr = 0;
    end else begin
      if (ret) begin
        m_occ = 0;
        ret_cnt[m_id]++;
      end
      if (acc) begin
        m_occ  = 1;
        m_lat  = LAT;
        m_id   = exp_g;
        m_prod = int'(req_a[exp_g*8 +: 8]) * int'(req_b[exp_g*8 +: 8]);
        m_ptr  = (exp_g + 1) % 4;
        acc_cnt[exp_g]++;
      end else if (m_occ && m_lat > 0) begin
        m_lat--;
      end
    end
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_valid = '0;
    rsp_ready = 1'b0;
    cycle();
    rst = 1'b0;
    rsp_log.delete();
    grant_log.delete();
  endtask

  task automatic drain();
    req_valid = '0;
    rsp_ready = 1'b1;
    for (int k = 0; k < 10 && busy !== 1'b0; k++) cycle();
    n_tests++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL drain_timeout: busy=%b expected 0", busy);
    end
  endtask

  task automatic test_reset();
    // Bring the DUT out of X before the model starts comparing.
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    req_valid = 4'b1111;
    req_a = 32'hFFFF_FFFF;
    req_b = 32'hFFFF_FFFF;
    rsp_ready = 1'b1;
    cycle();
    cycle();
    n_tests++;
    if (rsp_valid !== 1'b0 || busy !== 1'b0 || req_ready !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_ctrl: got valid=%b busy=%b ready=%b expected 0 0 0000", rsp_valid, busy, req_ready);
    end
    n_tests++;
    if (rsp_id !== 2'd0 || rsp_prod !== 16'd0) begin
      n_fail++;
      $display("FAIL reset_data: got id=%0d prod=%0d expected 0 0", rsp_id, rsp_prod);
    end
    do_reset();
  endtask

  task automatic test_single();
    do_reset();
    req_a = 32'h0000_00FF;
    req_b = 32'h0000_00FF;
    req_valid = 4'b0001;
    rsp_ready = 1'b1;
    cycle();
    req_valid = '0;
    for (int k = 0; k < LAT; k++) begin
      n_tests++;
      if (rsp_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL single_early: got rsp_valid=%b expected 0", rsp_valid);
      end
      cycle();
    end
    n_tests++;
    if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_prod !== 16'hFE01) begin
      n_fail++;
      $display("FAIL single_rsp: got valid=%b id=%0d prod=%h expected 1 0 fe01", rsp_valid, rsp_id, rsp_prod);
    end
    cycle();
    n_tests++;
    if (rsp_log.size() != 1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL single_retire: got %0d responses busy=%b expected 1 0", rsp_log.size(), busy);
    end
  endtask

  task automatic test_fairness();
    int exp_id[5]   = '{0, 1, 2, 3, 0};
    int exp_prod[5] = '{15, 63, 0, 256, 15};
    do_reset();
    req_a = {8'd128, 8'd0,   8'd7, 8'd3};
    req_b = {8'd2,   8'd200, 8'd9, 8'd5};
    req_valid = 4'b1111;
    rsp_ready = 1'b1;
    for (int k = 0; k < 40 && rsp_log.size() < 5; k++) cycle();
    n_tests++;
    if (rsp_log.size() < 5 || grant_log.size() < 5) begin
      n_fail++;
      $display("FAIL fair_timeout: got %0d responses expected 5", rsp_log.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        n_tests++;
        if (grant_log[i] != exp_id[i] || rsp_log[i].id != exp_id[i] || rsp_log[i].prod != exp_prod[i]) begin
          n_fail++;
          $display("FAIL fair_order[%0d]: got grant=%0d id=%0d prod=%0d expected %0d %0d %0d", i,
                   grant_log[i], rsp_log[i].id, rsp_log[i].prod, exp_id[i], exp_id[i], exp_prod[i]);
        end
      end
    end
    drain();
  endtask

  task automatic test_backpressure();
    do_reset();
    req_a = {8'd1, 8'd12, 8'd1, 8'd1};
    req_b = {8'd1, 8'd11, 8'd1, 8'd1};
    req_valid = 4'b0100;
    rsp_ready = 1'b0;
    cycle();
    req_valid = 4'b1011;
    for (int k = 0; k < LAT; k++) cycle();
    for (int k = 0; k < 5; k++) begin
      n_tests++;
      if (rsp_valid !== 1'b1 || rsp_prod !== 16'd132 || rsp_id !== 2'd2 || req_ready !== 4'b0000) begin
        n_fail++;
        $display("FAIL bp_hold[%0d]: got valid=%b prod=%0d id=%0d ready=%b expected 1 132 2 0000", k,
                 rsp_valid, rsp_prod, rsp_id, req_ready);
      end
      cycle();
    end
    req_valid = '0;
    rsp_ready = 1'b1;
    cycle();
    n_tests++;
    if (busy !== 1'b0 || rsp_log.size() != 1 || rsp_log[0].prod != 132) begin
      n_fail++;
      $display("FAIL bp_release: got busy=%b responses=%0d expected 0 1", busy, rsp_log.size());
    end
  endtask

  task automatic test_pointer_skip();
    do_reset();
    req_a = 32'h0403_0201;
    req_b = 32'h0807_0605;
    req_valid = 4'b0001;
    rsp_ready = 1'b1;
    cycle();
    drain();
    grant_log.delete();
    req_valid = 4'b1001;
    for (int k = 0; k < 12 && grant_log.size() < 2; k++) cycle();
    n_tests++;
    if (grant_log.size() < 2 || grant_log[0] != 3 || grant_log[1] != 0) begin
      n_fail++;
      $display("FAIL ptr_skip: got %0d grants first=%0d second=%0d expected 3 then 0", grant_log.size(),
               grant_log.size() > 0 ? grant_log[0] : -1, grant_log.size() > 1 ? grant_log[1] : -1);
    end
    drain();
  endtask

  task automatic test_reset_mid_op();
    do_reset();
    req_a = 32'h0009_0000;
    req_b = 32'h0007_0000;
    req_valid = 4'b0100;
    rsp_ready = 1'b0;
    cycle();
    req_valid = '0;
    for (int k = 0; k < LAT; k++) cycle();
    n_tests++;
    if (rsp_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL midrst_setup: got rsp_valid=%b expected 1", rsp_valid);
    end
    rst = 1'b1;
    rsp_ready = 1'b1;
    cycle();
    rst = 1'b0;
    rsp_ready = 1'b0;
    n_tests++;
    if (rsp_valid !== 1'b0 || busy !== 1'b0 || rsp_log.size() != 0) begin
      n_fail++;
      $display("FAIL midrst_discard: got valid=%b busy=%b responses=%0d expected 0 0 0", rsp_valid, busy, rsp_log.size());
    end
    grant_log.delete();
    req_valid = 4'b1111;
    cycle();
    n_tests++;
    if (grant_log.size() != 1 || grant_log[0] != 0) begin
      n_fail++;
      $display("FAIL midrst_ptr: got %0d grants first=%0d expected requester 0", grant_log.size(),
               grant_log.size() > 0 ? grant_log[0] : -1);
    end
    drain();
  endtask

  task automatic test_random();
    bit [3:0] pend;
    int       cycles;
    int       total;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      acc_cnt[i] = 0; ret_cnt[i] = 0; disc_cnt[i] = 0; dut_ret[i] = 0;
    end
    pend = '0;
    cycles = 0;
    total = 0;
    while (total < 10000 && cycles < 60000) begin
      for (int i = 0; i < 4; i++) begin
        if (!pend[i] && $urandom_range(0, 99) < 40) begin
          pend[i] = 1'b1;
          case ($urandom_range(0, 9))
            0:       begin req_a[i*8 +: 8] = 8'd255; req_b[i*8 +: 8] = 8'd255; end
            1:       begin req_a[i*8 +: 8] = 8'd0;   req_b[i*8 +: 8] = 8'($urandom); end
            default: begin req_a[i*8 +: 8] = 8'($urandom); req_b[i*8 +: 8] = 8'($urandom); end
          endcase
        end else if (pend[i] && $urandom_range(0, 99) < 5) begin
          pend[i] = 1'b0;
        end
      end
      req_valid = pend;
      rsp_ready = ($urandom_range(0, 99) < 80);
      rst = ($urandom_range(0, 499) == 0);
      cycle();
      cycles++;
      if (last_grant >= 0) begin
        pend[last_grant] = 1'b0;
        total++;
      end
    end
    rst = 1'b0;
    n_tests++;
    if (total < 10000) begin
      n_fail++;
      $display("FAIL rand_budget: got %0d accepts expected 10000", total);
    end
    drain();
    for (int i = 0; i < 4; i++) begin
      n_tests++;
      if (dut_ret[i] != ret_cnt[i] || acc_cnt[i] != ret_cnt[i] + disc_cnt[i]) begin
        n_fail++;
        $display("FAIL rand_count[%0d]: got retired=%0d expected %0d (accepted %0d discarded %0d)", i,
                 dut_ret[i], ret_cnt[i], acc_cnt[i], disc_cnt[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fairness();
    test_backpressure();
    test_pointer_skip();
    test_reset_mid_op();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
